// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: command constants, decoder states and command classification helpers.
package spi_slave_pkg;

    localparam logic [7:0] WR_REG_BASE = 8'h10;
    localparam logic [7:0] RD_REG_BASE = 8'h20;

    typedef enum logic [2:0] {IDLE, WR_DATA, RD_DUMMY, RD_SEND, SKIP} state_t;

    // The low two command bits carry the register address.
    function automatic logic is_wr_cmd(input logic [7:0] cmd);
        return cmd[7:2] == WR_REG_BASE[7:2];
    endfunction

    function automatic logic is_rd_cmd(input logic [7:0] cmd);
        return cmd[7:2] == RD_REG_BASE[7:2];
    endfunction

endpackage

// File: rtl/spi_slave_cmd_decoder.sv
// spi_slave_cmd_decoder: decodes SPI command bytes into register writes, delayed reads and error strobes.
module spi_slave_cmd_decoder
    import spi_slave_pkg::*;
#(
    parameter int REG_SIZE = 8
) (
    input  logic                sclk,
    input  logic                rstn,
    input  logic                cs_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic [7:0]          dummy_cycles,
    input  logic [REG_SIZE-1:0] rd_data,
    output logic [1:0]          rd_addr,
    output logic [REG_SIZE-1:0] wr_data,
    output logic [1:0]          wr_addr,
    output logic                wr_data_valid,
    output logic [REG_SIZE-1:0] tx_data,
    output logic                tx_load,
    output logic                cmd_err
);

    state_t     r_state;
    logic [1:0] r_addr_cnt;
    logic [7:0] r_dummy_cnt;

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_addr_cnt    <= '0;
            r_dummy_cnt   <= '0;
            rd_addr       <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
            tx_data       <= '0;
            wr_data_valid <= 1'b0;
            tx_load       <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            wr_data_valid <= 1'b0;
            tx_load       <= 1'b0;
            cmd_err       <= 1'b0;
            // Deselect ends the frame regardless of state or a coincident byte.
            if (cs_n) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (rx_valid) begin
                        if (is_wr_cmd(rx_data)) begin
                            r_addr_cnt <= rx_data[1:0];
                            r_state    <= WR_DATA;
                        end else if (is_rd_cmd(rx_data)) begin
                            rd_addr     <= rx_data[1:0];
                            r_dummy_cnt <= dummy_cycles;
                            r_state     <= (dummy_cycles != 8'd0) ? RD_DUMMY : RD_SEND;
                        end else begin
                            cmd_err <= 1'b1;
                            r_state <= SKIP;
                        end
                    end
                    WR_DATA: if (rx_valid) begin
                        wr_data       <= REG_SIZE'(rx_data);
                        wr_addr       <= r_addr_cnt;
                        wr_data_valid <= 1'b1;
                        r_addr_cnt    <= r_addr_cnt + 2'd1;
                    end
                    RD_DUMMY: begin
                        r_dummy_cnt <= r_dummy_cnt - 8'd1;
                        if (r_dummy_cnt == 8'd1) r_state <= RD_SEND;
                    end
                    RD_SEND: begin
                        tx_data <= rd_data;
                        tx_load <= 1'b1;
                        r_state <= SKIP;
                    end
                    default: r_state <= SKIP;
                endcase
            end
        end
    end

endmodule
